// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
// Used by dmem_arbiter and by dmem_arb_stats, which is only instantiated
// when DMEM_ARB_STATS_EN is defined.
package dmem_arb_pkg;

  localparam int ADDR_W_DEF    = 32;
  localparam int DATA_W_DEF    = 32;
  localparam int MAX_BURST_DEF = 4;

  // Which requester currently holds the memory.
  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_e;

  // One access request at the default widths.
  typedef struct packed {
    logic                  we;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
  } req_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/dmem_arb_stats.sv
// Activity counters for the data-memory arbiter.
// Only instantiated by dmem_arbiter when DMEM_ARB_STATS_EN is defined.
// Both counters saturate at 32'hFFFF_FFFF and clear on reset.
module dmem_arb_stats
  import dmem_arb_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_stall,
  input  logic        dbg_gnt,
  output logic [31:0] cpu_stall_cycles,
  output logic [31:0] dbg_grants
);

  // Count CPU stall cycles and debug accepts, saturating.
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_stall_cycles <= '0;
      dbg_grants       <= '0;
    end else begin
      if (cpu_stall) cpu_stall_cycles <= sat_inc32(cpu_stall_cycles);
      if (dbg_gnt)   dbg_grants       <= sat_inc32(dbg_grants);
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the core's Memory stage (CPU) and a
// debug/loader port (DBG). Per-cycle arbitration with bounded-burst
// fairness, same-cycle accept, 1-cycle load return.
// Optional feature: define DMEM_ARB_STATS_EN to add the cpu_stall_cycles
// and dbg_grants counter outputs.
//
// Handshake: a requester raises *_req with *_we/*_addr/*_wdata and holds
// all four unchanged until accepted. The CPU is accepted in any cycle with
// cpu_req=1 and cpu_stall=0; the debug port in any cycle with dbg_gnt=1.
// Accept is combinational in the request cycle. A load's data appears on
// *_rdata with *_rvalid=1 exactly one cycle after its accept; stores give
// no return.
//
// arb_owner / arb_burst_cnt expose the registered arbitration state.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic                           clk,
  input  logic                           reset,
  // CPU requester
  input  logic                           cpu_req,
  input  logic                           cpu_we,
  input  logic [ADDR_W-1:0]              cpu_addr,
  input  logic [DATA_W-1:0]              cpu_wdata,
  output logic                           cpu_stall,
  output logic [DATA_W-1:0]              cpu_rdata,
  output logic                           cpu_rvalid,
  // Debug requester
  input  logic                           dbg_req,
  input  logic                           dbg_we,
  input  logic [ADDR_W-1:0]              dbg_addr,
  input  logic [DATA_W-1:0]              dbg_wdata,
  output logic                           dbg_gnt,
  output logic [DATA_W-1:0]              dbg_rdata,
  output logic                           dbg_rvalid,
  // Memory side
  output logic                           mem_we,
  output logic [ADDR_W-1:0]              mem_addr,
  output logic [DATA_W-1:0]              mem_wdata,
  input  logic [DATA_W-1:0]              mem_rdata,
  // Arbitration state
  output owner_e                         arb_owner,
  output logic [$clog2(MAX_BURST+1)-1:0] arb_burst_cnt
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [31:0]                    cpu_stall_cycles,
  output logic [31:0]                    dbg_grants
`endif
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  owner_e              owner_q, owner_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                owner_req, other_req, burst_full;
  logic                win_cpu, win_dbg;
  logic                cpu_acc, dbg_acc;
  logic                cpu_load_q, dbg_load_q;
  logic [DATA_W-1:0]   cpu_rdata_q, dbg_rdata_q;

  // Requests seen from the owner's point of view.
  assign owner_req  = (owner_q == OWN_CPU) ? cpu_req : dbg_req;
  assign other_req  = (owner_q == OWN_CPU) ? dbg_req : cpu_req;
  assign burst_full = (cnt_q == CNT_W'(MAX_BURST));

  // Owner / burst state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q <= OWN_CPU;
      cnt_q   <= '0;
    end else begin
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  // Pick the winner and the next owner/burst count.
  // burst_cnt only counts grants to the owner while the other side waits;
  // any cycle where the non-owner is not requesting clears it, so there is
  // never fairness debt carried across an uncontended period.
  always_comb begin
    owner_d = owner_q;
    cnt_d   = cnt_q;
    win_cpu = 1'b0;
    win_dbg = 1'b0;
    if (!other_req) begin
      // Owner alone (or nobody): owner keeps the memory, no debt.
      cnt_d = '0;
      if (owner_req) begin
        win_cpu = (owner_q == OWN_CPU);
        win_dbg = (owner_q == OWN_DBG);
      end
    end else if (owner_req && !burst_full) begin
      // Contended and owner still has burst budget. burst_full is false
      // here, so the increment cannot pass MAX_BURST.
      cnt_d   = cnt_q + CNT_W'(1);
      win_cpu = (owner_q == OWN_CPU);
      win_dbg = (owner_q == OWN_DBG);
    end else begin
      // Other side alone, or owner exhausted its burst: hand over.
      owner_d = (owner_q == OWN_CPU) ? OWN_DBG : OWN_CPU;
      cnt_d   = CNT_W'(1);
      win_cpu = (owner_q == OWN_DBG);
      win_dbg = (owner_q == OWN_CPU);
    end
  end

  // No accept is visible while reset is held.
  assign cpu_acc   = win_cpu & ~reset;
  assign dbg_acc   = win_dbg & ~reset;
  assign cpu_stall = cpu_req & ~cpu_acc & ~reset;
  assign dbg_gnt   = dbg_acc;

  // Forward the winner's access to memory; CPU fields when idle.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    if (cpu_acc) begin
      mem_we = cpu_we;
    end else if (dbg_acc) begin
      mem_we    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end
  end

  // Load-return pipe and per-side read-data hold registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_load_q  <= 1'b0;
      dbg_load_q  <= 1'b0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      cpu_load_q <= cpu_acc & ~cpu_we;
      dbg_load_q <= dbg_acc & ~dbg_we;
      if (cpu_load_q) cpu_rdata_q <= mem_rdata;
      if (dbg_load_q) dbg_rdata_q <= mem_rdata;
    end
  end

  // Memory data is only valid in the return cycle, so pass it straight
  // through then and replay the captured copy afterwards.
  always_comb begin
    cpu_rvalid = cpu_load_q & ~reset;
    dbg_rvalid = dbg_load_q & ~reset;
    cpu_rdata  = cpu_rdata_q;
    dbg_rdata  = dbg_rdata_q;
    if (reset) begin
      cpu_rdata = '0;
      dbg_rdata = '0;
    end else begin
      if (cpu_load_q) cpu_rdata = mem_rdata;
      if (dbg_load_q) dbg_rdata = mem_rdata;
    end
  end

  assign arb_owner     = owner_q;
  assign arb_burst_cnt = cnt_q;

`ifdef DMEM_ARB_STATS_EN
  dmem_arb_stats u_stats (
    .clk              (clk),
    .reset            (reset),
    .cpu_stall        (cpu_stall),
    .dbg_gnt          (dbg_gnt),
    .cpu_stall_cycles (cpu_stall_cycles),
    .dbg_grants       (dbg_grants)
  );
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed arbitration scenarios, reset behaviour,
// random single-requester traffic; load data checked through a scoreboard.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
  logic        cpu_stall, cpu_rvalid, dbg_gnt, dbg_rvalid, mem_we;
  logic [31:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata, mem_rdata;
  owner_e      arb_owner;
  logic [2:0]  arb_burst_cnt;
`ifdef DMEM_ARB_STATS_EN
  logic [31:0] cpu_stall_cycles, dbg_grants;
`endif

  dmem_arbiter dut (
    .clk           (clk),
    .reset         (reset),
    .cpu_req       (cpu_req),
    .cpu_we        (cpu_we),
    .cpu_addr      (cpu_addr),
    .cpu_wdata     (cpu_wdata),
    .cpu_stall     (cpu_stall),
    .cpu_rdata     (cpu_rdata),
    .cpu_rvalid    (cpu_rvalid),
    .dbg_req       (dbg_req),
    .dbg_we        (dbg_we),
    .dbg_addr      (dbg_addr),
    .dbg_wdata     (dbg_wdata),
    .dbg_gnt       (dbg_gnt),
    .dbg_rdata     (dbg_rdata),
    .dbg_rvalid    (dbg_rvalid),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .arb_owner     (arb_owner),
    .arb_burst_cnt (arb_burst_cnt)
`ifdef DMEM_ARB_STATS_EN
    ,
    .cpu_stall_cycles (cpu_stall_cycles),
    .dbg_grants       (dbg_grants)
`endif
  );

  // ---------------- memory model ----------------
  function automatic logic [31:0] init_word(input int i);
    if (i == 24) return 32'hDEAD_BEEF;   // byte address 96
    return 32'hA5A5_0000 | 32'(i);
  endfunction

  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];

  // Synchronous-read, single-port memory seen by the DUT.
  always @(posedge clk) begin
    if (cyc == 0) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
    end else begin
      if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
      mem_rdata <= mem[mem_addr[9:2]];
    end
  end

  // ---------------- checking ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [31:0] cpu_exp_q[$];
  int          cpu_due_q[$];
  logic [31:0] dbg_exp_q[$];
  int          dbg_due_q[$];
  logic [31:0] cpu_last = '0;
  logic [31:0] dbg_last = '0;

  // Compare returns against the expected queues; rdata must hold otherwise.
  always @(negedge clk) begin
    if (!reset) begin
      if (cpu_due_q.size() > 0 && cpu_due_q[0] == cyc) begin
        check_eq("cpu_rvalid", cpu_rvalid, 1'b1);
        cpu_last = cpu_exp_q.pop_front();
        void'(cpu_due_q.pop_front());
        check_eq("cpu_rdata", cpu_rdata, cpu_last);
      end else begin
        check_eq("cpu_rvalid_idle", cpu_rvalid, 1'b0);
        check_eq("cpu_rdata_hold", cpu_rdata, cpu_last);
      end
      if (dbg_due_q.size() > 0 && dbg_due_q[0] == cyc) begin
        check_eq("dbg_rvalid", dbg_rvalid, 1'b1);
        dbg_last = dbg_exp_q.pop_front();
        void'(dbg_due_q.pop_front());
        check_eq("dbg_rdata", dbg_rdata, dbg_last);
      end else begin
        check_eq("dbg_rvalid_idle", dbg_rvalid, 1'b0);
        check_eq("dbg_rdata_hold", dbg_rdata, dbg_last);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // One cycle of requests with the expected winner(s); checks the
  // same-cycle handshake and memory forwarding at the falling edge.
  task automatic drive(input string tag,
                       input logic c_req, input logic c_we,
                       input logic [31:0] c_addr, input logic [31:0] c_wdata,
                       input logic d_req, input logic d_we,
                       input logic [31:0] d_addr, input logic [31:0] d_wdata,
                       input logic ecw, input logic edw);
    logic exp_we;
    @(posedge clk); #1;
    cpu_req = c_req; cpu_we = c_we; cpu_addr = c_addr; cpu_wdata = c_wdata;
    dbg_req = d_req; dbg_we = d_we; dbg_addr = d_addr; dbg_wdata = d_wdata;
    if (ecw) begin
      if (c_we) ref_mem[c_addr[9:2]] = c_wdata;
      else begin cpu_exp_q.push_back(ref_mem[c_addr[9:2]]); cpu_due_q.push_back(cyc + 1); end
    end
    if (edw) begin
      if (d_we) ref_mem[d_addr[9:2]] = d_wdata;
      else begin dbg_exp_q.push_back(ref_mem[d_addr[9:2]]); dbg_due_q.push_back(cyc + 1); end
    end
    exp_we = ecw ? c_we : (edw ? d_we : 1'b0);
    @(negedge clk);
    check_eq({tag, "_stall"}, cpu_stall, c_req & ~ecw);
    check_eq({tag, "_gnt"}, dbg_gnt, edw);
    check_eq({tag, "_mem_we"}, mem_we, exp_we);
    if (ecw || edw) check_eq({tag, "_mem_addr"}, mem_addr, ecw ? c_addr : d_addr);
    if (exp_we) check_eq({tag, "_mem_wdata"}, mem_wdata, ecw ? c_wdata : d_wdata);
  endtask

  task automatic idle();
    drive("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Contention with fixed requests: CPU store to 200, DBG load from 300.
  task automatic both(input string tag, input logic ecw);
    drive(tag, 1, 1, 32'd200, 32'h11, 1, 0, 32'd300, 0, ecw, ~ecw);
  endtask

  task automatic dbg_only(input string tag);
    drive(tag, 0, 0, 0, 0, 1, 0, 32'd300, 0, 0, 1);
  endtask

  task automatic cpu_only(input string tag);
    drive(tag, 1, 0, 32'd96, 0, 0, 0, 0, 0, 1, 0);
  endtask

  // Hold reset n cycles with both sides requesting; outputs must stay quiet.
  task automatic do_reset(input int n);
    @(posedge clk); #1;
    reset = 1'b1;
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'd40; cpu_wdata = 32'h55;
    dbg_req = 1; dbg_we = 1; dbg_addr = 32'd44; dbg_wdata = 32'h66;
    cpu_exp_q.delete(); cpu_due_q.delete();
    dbg_exp_q.delete(); dbg_due_q.delete();
    cpu_last = '0; dbg_last = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_eq("rst_cpu_stall", cpu_stall, 1'b0);
      check_eq("rst_dbg_gnt", dbg_gnt, 1'b0);
      check_eq("rst_mem_we", mem_we, 1'b0);
      check_eq("rst_cpu_rvalid", cpu_rvalid, 1'b0);
      check_eq("rst_dbg_rvalid", dbg_rvalid, 1'b0);
      check_eq("rst_cpu_rdata", cpu_rdata, 32'd0);
      check_eq("rst_dbg_rdata", dbg_rdata, 32'd0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
    @(negedge clk);
    check_eq("rst_owner", arb_owner, OWN_CPU);
    check_eq("rst_burst_cnt", arb_burst_cnt, 3'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
    do_reset(2);

    // Plain CPU store, then CPU load of a preloaded word.
    drive("st100", 1, 1, 32'd100, 32'd7, 0, 0, 0, 0, 1, 0);
    drive("ld96", 1, 0, 32'd96, 0, 0, 0, 0, 0, 1, 0);
    idle();

    // Back-to-back loads by alternating owners.
    drive("alt_c0", 1, 0, 32'd100, 0, 0, 0, 0, 0, 1, 0);
    drive("alt_d0", 0, 0, 0, 0, 1, 0, 32'd96, 0, 0, 1);
    drive("alt_c1", 1, 0, 32'd8, 0, 0, 0, 0, 0, 1, 0);
    drive("alt_d1", 0, 0, 0, 0, 1, 0, 32'd100, 0, 0, 1);
    idle();

    // Continuous contention: C,C,C,C,D,D,D,D repeating.
    do_reset(1);
    for (int i = 0; i < 16; i++) both("burst", ((i / 4) % 2) == 0);
    idle();
`ifdef DMEM_ARB_STATS_EN
    check_eq("stat_stall_cycles", cpu_stall_cycles, 32'd8);
    check_eq("stat_dbg_grants", dbg_grants, 32'd8);
`endif

    // DBG alone builds no debt; once CPU joins DBG gets 4 then CPU 4.
    do_reset(1);
    for (int i = 0; i < 3; i++) dbg_only("dbg_alone");
    check_eq("debt_owner", arb_owner, OWN_DBG);
    check_eq("debt_cnt", arb_burst_cnt, 3'd0);
    for (int i = 0; i < 4; i++) both("join_d", 1'b0);
    for (int i = 0; i < 4; i++) both("join_c", 1'b1);
    both("join_d2", 1'b0);
    idle();
    // An idle cycle after the CPU takes over clears its count: full 4 again.
    dbg_only("d_then_idle");
    idle();
    cpu_only("c_alone");
    idle();
    for (int i = 0; i < 4; i++) both("fresh_c", 1'b1);
    both("fresh_d", 1'b0);
    idle();

    // Reset the cycle after a load accept drops the return.
    drive("ld_rst", 1, 0, 32'd96, 0, 0, 0, 0, 0, 1, 0);
    do_reset(2);
    idle();

    // Random single-requester traffic.
    for (int i = 0; i < 40; i++) begin
      int          r;
      logic        we;
      logic [31:0] a, d;
      r  = $urandom_range(0, 2);
      we = 1'($urandom_range(0, 1));
      a  = 32'($urandom_range(0, 255)) << 2;
      d  = $urandom;
      case (r)
        1:       drive("rnd_cpu", 1, we, a, d, 0, 0, 0, 0, 1, 0);
        2:       drive("rnd_dbg", 0, 0, 0, 0, 1, we, a, d, 0, 1);
        default: idle();
      endcase
    end
    idle();
    idle();

    check_eq("cpu_q_drained", cpu_exp_q.size(), 0);
    check_eq("dbg_q_drained", dbg_exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
